// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall control slice.
// The load-enable struct is reused by the bubble muxes in the datapath.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} pctl_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // One active-low load enable per pipeline register, PC first.
  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } ld_en_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard equation, shared with the forwarding unit.
// x0 never carries a real dependency, so a load targeting it cannot stall.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_rs1_used,
  input  logic       i_id_rs2_used,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_mem_read & (i_ex_rd != REG_X0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: load enables and bubble strobes for the pipeline
// registers, memory wait-state timeout FSM and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_pc_ld_n,
  output logic             o_ifid_ld_n,
  output logic             o_idex_ld_n,
  output logic             o_exmem_ld_n,
  output logic             o_memwb_ld_n,
  output logic             o_ifid_bubble,
  output logic             o_idex_bubble,
  output logic             o_memwb_bubble,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT);

  pctl_state_t       r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_bus_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  ld_en_t w_ld_n;
  logic   w_ifid_bubble;
  logic   w_idex_bubble;
  logic   w_memwb_bubble;
  logic   w_mem_stall;
  logic   w_lu;

  hazard_detect u_hazard_detect (
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_rs1_used (i_id_rs1_used),
    .i_id_rs2_used (i_id_rs2_used),
    .i_ex_rd       (i_ex_rd),
    .i_ex_mem_read (i_ex_mem_read),
    .o_load_use    (w_lu)
  );

  // In MEM_WAIT the access is already outstanding, so only mem_ready releases it.
  always_comb begin
    w_ld_n         = '1;
    w_ifid_bubble  = 1'b0;
    w_idex_bubble  = 1'b0;
    w_memwb_bubble = 1'b0;
    w_mem_stall    = (r_state == RUN) ? (i_mem_req & ~i_mem_ready) : ~i_mem_ready;
    if (r_state == RUN || r_state == MEM_WAIT) begin
      if (w_mem_stall) begin
        w_memwb_bubble = 1'b1;
      end else if (i_ex_branch_taken) begin
        w_ld_n        = '0;
        w_ifid_bubble = 1'b1;
        w_idex_bubble = 1'b1;
      end else if (w_lu) begin
        w_ld_n        = '0;
        w_ld_n.pc     = 1'b1;
        w_ld_n.ifid   = 1'b1;
        w_idex_bubble = 1'b1;
      end else begin
        w_ld_n = '0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_state     <= INIT;
      r_wait_cnt  <= '0;
      r_bus_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (r_state != INIT && w_ld_n.pc && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      case (r_state)
        INIT: r_state <= RUN;
        RUN: begin
          if (i_mem_req & ~i_mem_ready) begin
            r_state    <= MEM_WAIT;
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (i_mem_ready) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            r_state   <= ERR;
            r_bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        ERR: r_state <= ERR;
        default: r_state <= INIT;
      endcase
    end
  end

  assign o_pc_ld_n      = w_ld_n.pc;
  assign o_ifid_ld_n    = w_ld_n.ifid;
  assign o_idex_ld_n    = w_ld_n.idex;
  assign o_exmem_ld_n   = w_ld_n.exmem;
  assign o_memwb_ld_n   = w_ld_n.memwb;
  assign o_ifid_bubble  = w_ifid_bubble;
  assign o_idex_bubble  = w_idex_bubble;
  assign o_memwb_bubble = w_memwb_bubble;
  assign o_bus_err      = r_bus_err;
  assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazards, branch squash, memory waits,
// timeout, async reset, plus a narrow-counter instance to show saturation.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       clr;
  logic [4:0] idRs1;
  logic [4:0] idRs2;
  logic       idRs1Used;
  logic       idRs2Used;
  logic [4:0] exRd;
  logic       exMemRead;
  logic       exBranchTaken;
  logic       memReq;
  logic       memReady;

  logic        pcLdN, ifidLdN, idexLdN, exmemLdN, memwbLdN;
  logic        ifidBubble, idexBubble, memwbBubble;
  logic        busErr;
  logic [31:0] stallCnt;

  logic        pcLdN4, ifidLdN4, idexLdN4, exmemLdN4, memwbLdN4;
  logic        ifidBubble4, idexBubble4, memwbBubble4;
  logic        busErr4;
  logic [3:0]  stallCnt4;

  int checkCount = 0;
  int failCount  = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
    .i_clk(clk), .i_clr(clr),
    .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_rs1_used(idRs1Used), .i_id_rs2_used(idRs2Used),
    .i_ex_rd(exRd), .i_ex_mem_read(exMemRead),
    .i_ex_branch_taken(exBranchTaken),
    .i_mem_req(memReq), .i_mem_ready(memReady),
    .o_pc_ld_n(pcLdN), .o_ifid_ld_n(ifidLdN), .o_idex_ld_n(idexLdN),
    .o_exmem_ld_n(exmemLdN), .o_memwb_ld_n(memwbLdN),
    .o_ifid_bubble(ifidBubble), .o_idex_bubble(idexBubble),
    .o_memwb_bubble(memwbBubble),
    .o_bus_err(busErr), .o_stall_cnt(stallCnt)
  );

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_clr(clr),
    .i_id_rs1(idRs1), .i_id_rs2(idRs2),
    .i_id_rs1_used(idRs1Used), .i_id_rs2_used(idRs2Used),
    .i_ex_rd(exRd), .i_ex_mem_read(exMemRead),
    .i_ex_branch_taken(exBranchTaken),
    .i_mem_req(memReq), .i_mem_ready(memReady),
    .o_pc_ld_n(pcLdN4), .o_ifid_ld_n(ifidLdN4), .o_idex_ld_n(idexLdN4),
    .o_exmem_ld_n(exmemLdN4), .o_memwb_ld_n(memwbLdN4),
    .o_ifid_bubble(ifidBubble4), .o_idex_bubble(idexBubble4),
    .o_memwb_bubble(memwbBubble4),
    .o_bus_err(busErr4), .o_stall_cnt(stallCnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkPipe(input string tag, input logic [4:0] expLd,
                           input logic [2:0] expBub);
    checkOutput({tag, "_ld"}, {27'd0, pcLdN, ifidLdN, idexLdN, exmemLdN, memwbLdN},
                {27'd0, expLd});
    checkOutput({tag, "_bub"}, {29'd0, ifidBubble, idexBubble, memwbBubble},
                {29'd0, expBub});
  endtask

  task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2,
                               input logic [4:0] rd, input logic ld,
                               input logic br, input logic req, input logic rdy);
    idRs1 = rs1; idRs2 = rs2; idRs1Used = u1; idRs2Used = u2;
    exRd = rd; exMemRead = ld; exBranchTaken = br;
    memReq = req; memReady = rdy;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #11;
    checkPipe("reset", 5'b11111, 3'b000);
    checkOutput("resetBusErr", {31'd0, busErr}, 32'd0);
    checkOutput("resetCnt", stallCnt, 32'd0);

    clr = 1'b0;
    #1;
    checkPipe("init", 5'b11111, 3'b000);
    stepClock();
    checkPipe("run", 5'b00000, 3'b000);
    checkOutput("runCnt", stallCnt, 32'd0);

    // Load-use on rs1, then on rs2
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkPipe("luRs1", 5'b11000, 3'b010);
    stepClock();
    checkOutput("luRs1Cnt", stallCnt, 32'd1);
    applyStimulus(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    checkPipe("luRs2", 5'b11000, 3'b010);
    stepClock();
    checkOutput("luRs2Cnt", stallCnt, 32'd2);

    // No hazard: load into x0, register not used, or not a load
    applyStimulus(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkPipe("luX0", 5'b00000, 3'b000);
    applyStimulus(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkPipe("luUnused", 5'b00000, 3'b000);
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkPipe("noLoad", 5'b00000, 3'b000);
    stepClock();
    checkOutput("noStallCnt", stallCnt, 32'd2);

    // Branch wins over a simultaneous load-use
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkPipe("branchLu", 5'b00000, 3'b110);
    stepClock();
    checkOutput("branchCnt", stallCnt, 32'd2);

    // Memory wait: three stalled cycles, then ready
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkPipe("memWait1", 5'b11111, 3'b001);
    stepClock();
    applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    checkPipe("memWaitDefer", 5'b11111, 3'b001);
    stepClock();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkPipe("memWait3", 5'b11111, 3'b001);
    stepClock();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkPipe("memReady", 5'b00000, 3'b000);
    stepClock();
    checkOutput("memCnt", stallCnt, 32'd5);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkPipe("readyNoReq", 5'b00000, 3'b000);
    stepClock();
    checkOutput("readyNoReqCnt", stallCnt, 32'd5);

    // Fresh start, then let the access time out and sit in ERR
    clr = 1'b1;
    #1;
    clr = 1'b0;
    stepClock();
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      checkPipe("timeout", 5'b11111, (i - 1 >= 16) ? 3'b000 : 3'b001);
      stepClock();
      checkOutput("busErr", {31'd0, busErr}, (i >= 16) ? 32'd1 : 32'd0);
      checkOutput("cnt4Sat", {28'd0, stallCnt4}, (i > 15) ? 32'd15 : i);
    end
    checkOutput("errCnt", stallCnt, 32'd20);
    applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkPipe("errHold", 5'b11111, 3'b000);
    stepClock();
    checkOutput("errSticky", {31'd0, busErr}, 32'd1);

    // Asynchronous clear between clock edges
    #2;
    clr = 1'b1;
    #1;
    checkPipe("asyncClr", 5'b11111, 3'b000);
    checkOutput("asyncBusErr", {31'd0, busErr}, 32'd0);
    checkOutput("asyncCnt", stallCnt, 32'd0);
    checkOutput("asyncCnt4", {28'd0, stallCnt4}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
